// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared CAN decoder types, field widths and frame constants
package can_pkg;

  typedef enum logic [4:0] {
    IDLE, ID_A, RTR_SRR, IDE, ID_B, RTR, R1, R0, DLC, DATA,
    CRC, CRC_DELIM, ACK_SLOT, ACK_DELIM, EOF, INTERMISSION, ERROR
  } state_e;

  localparam int ID_A_W           = 11;
  localparam int ID_B_W           = 18;
  localparam int DLC_W            = 4;
  localparam int DATA_W           = 64;
  localparam int CRC_W            = 15;
  localparam int STUFF_LIMIT      = 5;
  localparam int EOF_LEN          = 7;
  localparam int INTERMISSION_LEN = 3;
  localparam int MAX_DATA_BYTES   = 8;

  typedef struct packed {
    logic              sof;
    logic [ID_A_W-1:0] id_a;
    logic              rtr_srr_temp;
    logic              ide;
    logic              rtr;
    logic              srr;
    logic              r1;
    logic              r0;
    logic [ID_B_W-1:0] id_b;
    logic [DLC_W-1:0]  dlc;
    logic [DATA_W-1:0] data;
    logic [CRC_W-1:0]  crc;
    logic              crc_delim;
    logic              ack_slot;
    logic              ack_delim;
  } fields_t;

  // Number of data bits carried by the frame; remote frames carry none and
  // DLC codes above 8 still mean 8 bytes.
  function automatic logic [6:0] data_bits(input logic rtr, input logic [DLC_W-1:0] dlc);
    if (rtr) begin
      return 7'd0;
    end else if (dlc > 4'(MAX_DATA_BYTES)) begin
      return 7'(MAX_DATA_BYTES * 8);
    end else begin
      return {dlc, 3'b000};
    end
  endfunction

endpackage

// File: rtl/can_decoder_destuffer.sv
// rtl/can_decoder_destuffer.sv - sample strobe edge detect and CAN bit destuffing
module can_bit_destuffer
  import can_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic rx_bit_i,
  input  logic sample_point_i,
  input  logic sof_arm_i,
  input  logic destuff_en_i,
  output logic bit_stb_o,
  output logic stuff_bit_o,
  output logic stuff_err_o
);

  logic       sp_q;
  logic       last_q, last_d;
  logic [2:0] run_q, run_d;
  logic       at_limit;

  assign bit_stb_o   = sample_point_i & ~sp_q;
  assign at_limit    = (run_q == 3'(STUFF_LIMIT));
  assign stuff_bit_o = bit_stb_o & destuff_en_i & at_limit & (rx_bit_i != last_q);
  assign stuff_err_o = bit_stb_o & destuff_en_i & at_limit & (rx_bit_i == last_q);

  // Track the current run of equal bits; a stuff bit starts a fresh run of one.
  always_comb begin
    last_d = last_q;
    run_d  = run_q;
    if (bit_stb_o) begin
      if (sof_arm_i && !rx_bit_i) begin
        last_d = 1'b0;
        run_d  = 3'd1;
      end else if (destuff_en_i) begin
        if (at_limit || (rx_bit_i != last_q)) begin
          last_d = rx_bit_i;
          run_d  = 3'd1;
        end else begin
          run_d = run_q + 3'd1;
        end
      end
    end
  end

  // Strobe history and run state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sp_q   <= 1'b0;
      last_q <= 1'b1;
      run_q  <= 3'd0;
    end else begin
      sp_q   <= sample_point_i;
      last_q <= last_d;
      run_q  <= run_d;
    end
  end

endmodule

// File: rtl/can_decoder.sv
// rtl/can_decoder.sv - CAN frame field decoder driven by bit sample strobes
module can_decoder
  import can_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                rx_bit,
  input  logic                sample_point,
  output logic                field_start_of_frame,
  output logic [ID_A_W-1:0]   field_id_a,
  output logic                field_ide,
  output logic                field_rtr,
  output logic                field_srr,
  output logic                field_reserved1,
  output logic                field_reserved0,
  output logic [ID_B_W-1:0]   field_id_b,
  output logic [DLC_W-1:0]    field_dlc,
  output logic [DATA_W-1:0]   field_data,
  output logic [CRC_W-1:0]    field_crc,
  output logic                field_crc_delimiter,
  output logic                field_ack_slot,
  output logic                field_ack_delimiter,
  output logic                rtr_srr_temp
);

  state_e     state_q, state_d;
  logic [6:0] cnt_q, cnt_d, cnt_inc, nbits;
  fields_t    f_q, f_d;
  logic       bit_stb, stuff_bit, stuff_err, sof_arm, destuff_en;

  assign sof_arm    = state_q inside {IDLE, INTERMISSION};
  assign destuff_en = state_q inside {ID_A, RTR_SRR, IDE, ID_B, RTR, R1, R0, DLC, DATA, CRC};
  assign cnt_inc    = cnt_q + 7'd1;
  assign nbits      = data_bits(f_q.rtr, f_q.dlc);

  can_bit_destuffer u_destuffer (
    .clock          (clock),
    .reset          (reset),
    .rx_bit_i       (rx_bit),
    .sample_point_i (sample_point),
    .sof_arm_i      (sof_arm),
    .destuff_en_i   (destuff_en),
    .bit_stb_o      (bit_stb),
    .stuff_bit_o    (stuff_bit),
    .stuff_err_o    (stuff_err)
  );

  // Frame walker: one data bit per strobe, stuff bits skipped, fields shifted MSB first.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    if (bit_stb) begin
      if (stuff_err) begin
        state_d = ERROR;
        cnt_d   = '0;
      end else if (!stuff_bit) begin
        unique case (state_q)
          IDLE, INTERMISSION: begin
            if (!rx_bit) begin
              f_d     = '0;
              state_d = ID_A;
              cnt_d   = '0;
            end else if (state_q == INTERMISSION) begin
              if (cnt_q == 7'(INTERMISSION_LEN - 1)) begin
                state_d = IDLE;
                cnt_d   = '0;
              end else cnt_d = cnt_inc;
            end
          end
          ID_A: begin
            f_d.id_a = {f_q.id_a[ID_A_W-2:0], rx_bit};
            if (cnt_q == 7'(ID_A_W - 1)) begin
              state_d = RTR_SRR;
              cnt_d   = '0;
            end else cnt_d = cnt_inc;
          end
          RTR_SRR: begin
            f_d.rtr_srr_temp = rx_bit;
            state_d = IDE;
          end
          IDE: begin
            f_d.ide = rx_bit;
            if (!rx_bit) begin
              f_d.rtr = f_q.rtr_srr_temp;
              f_d.srr = 1'b0;
              state_d = R0;
            end else begin
              f_d.srr = f_q.rtr_srr_temp;
              state_d = ID_B;
            end
          end
          ID_B: begin
            f_d.id_b = {f_q.id_b[ID_B_W-2:0], rx_bit};
            if (cnt_q == 7'(ID_B_W - 1)) begin
              state_d = RTR;
              cnt_d   = '0;
            end else cnt_d = cnt_inc;
          end
          RTR: begin
            f_d.rtr = rx_bit;
            state_d = R1;
          end
          R1: begin
            f_d.r1  = rx_bit;
            state_d = R0;
          end
          R0: begin
            f_d.r0  = rx_bit;
            state_d = DLC;
          end
          DLC: begin
            f_d.dlc = {f_q.dlc[DLC_W-2:0], rx_bit};
            if (cnt_q == 7'(DLC_W - 1)) begin
              cnt_d   = '0;
              state_d = (data_bits(f_q.rtr, f_d.dlc) == 7'd0) ? CRC : DATA;
            end else cnt_d = cnt_inc;
          end
          DATA: begin
            f_d.data = {f_q.data[DATA_W-2:0], rx_bit};
            if (cnt_q == nbits - 7'd1) begin
              state_d = CRC;
              cnt_d   = '0;
            end else cnt_d = cnt_inc;
          end
          CRC: begin
            f_d.crc = {f_q.crc[CRC_W-2:0], rx_bit};
            if (cnt_q == 7'(CRC_W - 1)) begin
              state_d = CRC_DELIM;
              cnt_d   = '0;
            end else cnt_d = cnt_inc;
          end
          CRC_DELIM: begin
            f_d.crc_delim = rx_bit;
            state_d = rx_bit ? ACK_SLOT : ERROR;
          end
          ACK_SLOT: begin
            f_d.ack_slot = rx_bit;
            state_d = ACK_DELIM;
          end
          ACK_DELIM: begin
            f_d.ack_delim = rx_bit;
            state_d = rx_bit ? EOF : ERROR;
          end
          EOF: begin
            if (!rx_bit) begin
              state_d = ERROR;
              cnt_d   = '0;
            end else if (cnt_q == 7'(EOF_LEN - 1)) begin
              state_d = INTERMISSION;
              cnt_d   = '0;
            end else cnt_d = cnt_inc;
          end
          ERROR: begin
            if (!rx_bit) begin
              cnt_d = '0;
            end else if (cnt_q == 7'(EOF_LEN - 1)) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else cnt_d = cnt_inc;
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  // State, bit counter and field registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
    end
  end

  assign field_start_of_frame = f_q.sof;
  assign field_id_a           = f_q.id_a;
  assign field_ide            = f_q.ide;
  assign field_rtr            = f_q.rtr;
  assign field_srr            = f_q.srr;
  assign field_reserved1      = f_q.r1;
  assign field_reserved0      = f_q.r0;
  assign field_id_b           = f_q.id_b;
  assign field_dlc            = f_q.dlc;
  assign field_data           = f_q.data;
  assign field_crc            = f_q.crc;
  assign field_crc_delimiter  = f_q.crc_delim;
  assign field_ack_slot       = f_q.ack_slot;
  assign field_ack_delimiter  = f_q.ack_delim;
  assign rtr_srr_temp         = f_q.rtr_srr_temp;

endmodule

// File: tb/tb_can_decoder.sv
// tb/tb_can_decoder.sv - directed self-checking bench for can_decoder
module tb_can_decoder;
  import can_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rx_bit = 1'b1;
  logic        sample_point = 1'b0;
  logic        field_start_of_frame;
  logic [10:0] field_id_a;
  logic        field_ide, field_rtr, field_srr, field_reserved1, field_reserved0;
  logic [17:0] field_id_b;
  logic [3:0]  field_dlc;
  logic [63:0] field_data;
  logic [14:0] field_crc;
  logic        field_crc_delimiter, field_ack_slot, field_ack_delimiter;
  logic        rtr_srr_temp;
  logic [121:0] all_out;

  int total = 0;
  int bad   = 0;
  bit fq[$];
  bit sq[$];

  always #5 clock = ~clock;

  can_decoder dut (
    .clock                (clock),
    .reset                (reset),
    .rx_bit               (rx_bit),
    .sample_point         (sample_point),
    .field_start_of_frame (field_start_of_frame),
    .field_id_a           (field_id_a),
    .field_ide            (field_ide),
    .field_rtr            (field_rtr),
    .field_srr            (field_srr),
    .field_reserved1      (field_reserved1),
    .field_reserved0      (field_reserved0),
    .field_id_b           (field_id_b),
    .field_dlc            (field_dlc),
    .field_data           (field_data),
    .field_crc            (field_crc),
    .field_crc_delimiter  (field_crc_delimiter),
    .field_ack_slot       (field_ack_slot),
    .field_ack_delimiter  (field_ack_delimiter),
    .rtr_srr_temp         (rtr_srr_temp)
  );

  assign all_out = {field_start_of_frame, field_id_a, field_ide, field_rtr, field_srr,
                    field_reserved1, field_reserved0, field_id_b, field_dlc, field_data,
                    field_crc, field_crc_delimiter, field_ack_slot, field_ack_delimiter,
                    rtr_srr_temp};

  task automatic send_bit(input logic b);
    @(negedge clock);
    rx_bit = b;
    sample_point = 1'b1;
    @(negedge clock);
    sample_point = 1'b0;
  endtask

  task automatic push_bits(input logic [63:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) fq.push_back(v[i]);
  endtask

  // Insert stuff bits into fq (SOF..CRC), then append delimiters, ack, EOF, intermission.
  task automatic stuff_frame();
    int cnt;
    bit last;
    cnt = 0;
    last = 1'b1;
    sq.delete();
    for (int i = 0; i < fq.size(); i++) begin
      sq.push_back(fq[i]);
      if (fq[i] == last) cnt++;
      else begin
        last = fq[i];
        cnt = 1;
      end
      if (cnt == 5 && i != fq.size() - 1) begin
        sq.push_back(!last);
        last = !last;
        cnt = 1;
      end
    end
    sq.push_back(1'b1);
    sq.push_back(1'b0);
    sq.push_back(1'b1);
    for (int i = 0; i < 10; i++) sq.push_back(1'b1);
  endtask

  task automatic build_std(input logic [10:0] id, input logic [3:0] dlc,
                           input logic [63:0] data, input int nbytes, input logic [14:0] crc);
    fq.delete();
    push_bits(64'd0, 1);
    push_bits({53'd0, id}, 11);
    push_bits(64'd0, 3);
    push_bits({60'd0, dlc}, 4);
    if (nbytes > 0) push_bits(data, nbytes * 8);
    push_bits({49'd0, crc}, 15);
    stuff_frame();
  endtask

  task automatic build_ext();
    fq.delete();
    push_bits(64'd0, 1);
    push_bits(64'h1AB, 11);
    push_bits(64'd3, 2);
    push_bits(64'h2AAAA, 18);
    push_bits(64'd0, 3);
    push_bits(64'd0, 4);
    push_bits(64'h5555, 15);
    stuff_frame();
  endtask

  task automatic send_n(input int n);
    for (int i = 0; i < n && i < sq.size(); i++) send_bit(sq[i]);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if (all_out !== '0) begin
      bad++;
      $display("FAIL reset_outputs got %h want 0", all_out);
    end
    total++;
    if (dut.state_q !== IDLE) begin
      bad++;
      $display("FAIL reset_state got %0d want %0d", int'(dut.state_q), int'(IDLE));
    end
    reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_ref_stream();
    logic [44:0] s;
    s = 45'b011001110010100000110000100100010011011111111;
    for (int i = 44; i >= 0; i--) send_bit(s[i]);
    total++;
    if (dut.state_q !== INTERMISSION) begin
      bad++;
      $display("FAIL ref_after_eof got %0d want %0d", int'(dut.state_q), int'(INTERMISSION));
    end
    repeat (3) send_bit(1'b1);
    total++;
    if (dut.state_q !== IDLE) begin
      bad++;
      $display("FAIL ref_idle got %0d want %0d", int'(dut.state_q), int'(IDLE));
    end
    total++;
    if ({field_id_a, rtr_srr_temp, field_rtr, field_ide, field_reserved0, field_srr} !== {11'h672, 5'b11000}) begin
      bad++;
      $display("FAIL ref_header got %h/%b%b%b%b%b want 672/11000", field_id_a, rtr_srr_temp,
               field_rtr, field_ide, field_reserved0, field_srr);
    end
    total++;
    if ({field_dlc, field_data, field_crc} !== {4'h1, 64'h0, 15'h489}) begin
      bad++;
      $display("FAIL ref_body got dlc=%h data=%h crc=%h want 1/0/489", field_dlc, field_data, field_crc);
    end
    total++;
    if ({field_crc_delimiter, field_ack_slot, field_ack_delimiter} !== 3'b101) begin
      bad++;
      $display("FAIL ref_delims got %b%b%b want 101", field_crc_delimiter, field_ack_slot, field_ack_delimiter);
    end
  endtask

  task automatic test_std_data(input string tag);
    build_std(11'h123, 4'h2, 64'hA53C, 2, 15'h2AAA);
    send_n(sq.size());
    total++;
    if ({field_id_a, field_ide, field_rtr, field_srr, field_dlc} !== {11'h123, 3'b000, 4'h2}) begin
      bad++;
      $display("FAIL %s_header got id=%h ide=%b rtr=%b srr=%b dlc=%h want 123/0/0/0/2", tag,
               field_id_a, field_ide, field_rtr, field_srr, field_dlc);
    end
    total++;
    if (field_data !== 64'h000000000000A53C) begin
      bad++;
      $display("FAIL %s_data got %h want 000000000000a53c", tag, field_data);
    end
    total++;
    if (field_crc !== 15'h2AAA || dut.state_q !== IDLE) begin
      bad++;
      $display("FAIL %s_crc_state got crc=%h state=%0d want 2aaa/%0d", tag, field_crc,
               int'(dut.state_q), int'(IDLE));
    end
  endtask

  task automatic test_extended(input string tag);
    build_ext();
    send_n(sq.size());
    total++;
    if ({field_id_a, field_ide, field_srr, rtr_srr_temp, field_rtr} !== {11'h1AB, 4'b1110}) begin
      bad++;
      $display("FAIL %s_header got id_a=%h ide=%b srr=%b tmp=%b rtr=%b want 1ab/1/1/1/0", tag,
               field_id_a, field_ide, field_srr, rtr_srr_temp, field_rtr);
    end
    total++;
    if ({field_id_b, field_dlc, field_data, field_crc} !== {18'h2AAAA, 4'h0, 64'h0, 15'h5555}) begin
      bad++;
      $display("FAIL %s_body got id_b=%h dlc=%h data=%h crc=%h want 2aaaa/0/0/5555", tag,
               field_id_b, field_dlc, field_data, field_crc);
    end
  endtask

  task automatic test_stuff_error();
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (5) send_bit(1'b0);
    total++;
    if (dut.state_q !== ID_A) begin
      bad++;
      $display("FAIL stuff_five_ok got %0d want %0d", int'(dut.state_q), int'(ID_A));
    end
    send_bit(1'b0);
    total++;
    if (dut.state_q !== ERROR || field_id_a !== 11'h020) begin
      bad++;
      $display("FAIL stuff_error got state=%0d id_a=%h want %0d/020", int'(dut.state_q),
               field_id_a, int'(ERROR));
    end
    repeat (6) send_bit(1'b1);
    total++;
    if (dut.state_q !== ERROR) begin
      bad++;
      $display("FAIL error_six_rec got %0d want %0d", int'(dut.state_q), int'(ERROR));
    end
    send_bit(1'b1);
    total++;
    if (dut.state_q !== IDLE) begin
      bad++;
      $display("FAIL error_seven_rec got %0d want %0d", int'(dut.state_q), int'(IDLE));
    end
    test_std_data("recover");
  endtask

  task automatic test_dlc15();
    build_std(11'h456, 4'hF, 64'h0123456789ABCDEF, 8, 15'h2AAA);
    send_n(sq.size());
    total++;
    if (field_dlc !== 4'hF || field_data !== 64'h0123456789ABCDEF) begin
      bad++;
      $display("FAIL dlc15 got dlc=%h data=%h want f/0123456789abcdef", field_dlc, field_data);
    end
    total++;
    if (field_id_a !== 11'h456 || field_crc !== 15'h2AAA) begin
      bad++;
      $display("FAIL dlc15_id_crc got id=%h crc=%h want 456/2aaa", field_id_a, field_crc);
    end
  endtask

  task automatic test_reset_in_data();
    build_std(11'h123, 4'h2, 64'hA53C, 2, 15'h2AAA);
    send_n(22);
    total++;
    if (dut.state_q !== DATA) begin
      bad++;
      $display("FAIL mid_data_state got %0d want %0d", int'(dut.state_q), int'(DATA));
    end
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    total++;
    if (all_out !== '0 || dut.state_q !== IDLE) begin
      bad++;
      $display("FAIL async_reset got %h state=%0d want 0/%0d", all_out, int'(dut.state_q), int'(IDLE));
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    test_extended("after_reset");
  endtask

  initial begin
    test_reset();
    test_ref_stream();
    test_std_data("std");
    test_extended("ext");
    test_stuff_error();
    test_dlc15();
    test_reset_in_data();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
